immediate_encoder: RTL and testbench
====================================

IMMEDIATE_ENCODER -- requirements
Module: immediate_encoder

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous and active-low.
REQ-003 SHALL have ports: in_valid  in  1  request valid.
REQ-004 SHALL have ports: in_ready  out  1  encoder can accept a request.
REQ-005 SHALL have ports: imm_value  in  32  immediate to encode, two's complement.
REQ-006 SHALL have ports: imm_type  in  3  0=I, 1=S, 2=B, 3=U, 4=J, 5..7 illegal.
REQ-007 SHALL have ports: base_instr  in  32  instruction carrying all non-immediate fields.
REQ-008 SHALL have ports: out_valid  out  1  encoded result valid.
REQ-009 SHALL have ports: out_ready  in  1  consumer accepts the result.
REQ-010 SHALL have ports: out_instr  out  32  encoded instruction.
REQ-011 SHALL have ports: out_err  out  3  error flags: [0] range, [1] alignment, [2] illegal type.
REQ-012 SHALL have ports: err_count  out  16  saturating count of errored requests.

Function
REQ-013 SHALL accept a request when in_valid && in_ready are both high at a clk edge (push).
REQ-014 SHALL deliver a result when out_valid && out_ready are both high at a clk edge (pop).
REQ-015 SHALL buffer results in a 2-entry FIFO; in_ready = (occupancy < 2), with no dependence on out_ready.
REQ-016 SHALL present a result 1 cycle after it is pushed into an empty FIFO; there SHALL be no combinational in-to-out path.
REQ-017 SHALL deliver results in strict acceptance order.
REQ-018 SHALL, on simultaneous push and pop at occupancy 1, keep occupancy at 1 and present the new entry on the next cycle.
REQ-019 SHALL hold out_instr and out_err stable while out_valid && !out_ready.
REQ-020 SHALL copy base_instr bits not covered by the immediate into out_instr unchanged.
REQ-021 SHALL encode I-type as: instr[31:20]=imm[11:0].
REQ-022 SHALL flag I-type range error unless imm[31:11] are all equal.
REQ-023 SHALL encode S-type as: instr[31:25]=imm[11:5], instr[11:7]=imm[4:0].
REQ-024 SHALL apply the I-type range rule to S-type.
REQ-025 SHALL encode B-type as: instr[31]=imm[12], instr[7]=imm[11], instr[30:25]=imm[10:5], instr[11:8]=imm[4:1].
REQ-026 SHALL flag B-type range error unless imm[31:12] are all equal, and alignment error if imm[0]=1.
REQ-027 SHALL encode U-type as: instr[31:12]=imm[31:12].
REQ-028 SHALL never flag range error for U-type, and SHALL flag alignment error if imm[11:0]!=0.
REQ-029 SHALL encode J-type as: instr[31]=imm[20], instr[30:21]=imm[10:1], instr[20]=imm[11], instr[19:12]=imm[19:12].
REQ-030 SHALL flag J-type range error unless imm[31:20] are all equal, and alignment error if imm[0]=1.
REQ-031 SHALL, for illegal types, output out_instr=base_instr with out_err=3'b100.
REQ-032 SHALL still insert truncated immediate bits into out_instr when range or alignment errors are flagged.
REQ-033 SHALL increment err_count by 1 on each push with any out_err bit set, saturating at 16'hFFFF.
REQ-034 SHALL decide errors and the count update at push time, independent of pop timing.

Reset
REQ-035 SHALL, while rst_n=0, immediately force: occupancy 0, out_valid=0, in_ready=0, out_instr=0, out_err=0, err_count=0.
REQ-036 SHALL discard buffered entries on reset, including reset asserted mid-operation.
REQ-037 SHALL raise in_ready on the first clk edge after rst_n deasserts.

Verification
REQ-038 Test: I-type, imm=0xFFFFF800, base=0x00000013 -> out_instr=0x80000013, out_err=000, out_valid 1 cycle after push.
REQ-039 Test: B-type, imm=0x00000FFE, base=0x00000063 -> out_instr=0x7E000FE3, out_err=000; then imm=0x00001000 -> out_err=001.
REQ-040 Test: U-type, imm=0x12345000, base=0x000000B7 -> out_instr=0x123450B7; then J-type imm=0x00000001 -> out_err=010, err_count=1.
REQ-041 Test: out_ready=0 with 3 back-to-back requests -> in_ready low after 2 pushes; after out_ready=1, results arrive in order and the 3rd is accepted.
REQ-042 Test: imm_type=6, base=0xDEADBEEF -> out_instr=0xDEADBEEF, out_err=100.
REQ-043 Test: rst_n pulsed low with 2 entries buffered -> out_valid=0 and err_count=0 asynchronously, and no stale result after release.

Source files
------------

// File: rtl/immediate_encoder_if.sv
// Request/result bus of the immediate encoder: request handshake in, result handshake out,
// plus the running error count.
interface immediate_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] imm_value;
  logic [2:0]  imm_type;
  logic [31:0] base_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [2:0]  out_err;
  logic [15:0] err_count;

  modport slave (
    input  in_valid, imm_value, imm_type, base_instr, out_ready,
    output in_ready, out_valid, out_instr, out_err, err_count
  );

  modport master (
    output in_valid, imm_value, imm_type, base_instr, out_ready,
    input  in_ready, out_valid, out_instr, out_err, err_count
  );
endinterface

// File: rtl/immediate_encoder.sv
// Inserts a RISC-V style immediate into a base instruction, flags range/alignment/type errors,
// and queues the results in a 2-entry FIFO with a saturating error counter.
module immediate_encoder (
  input  logic                clk,
  input  logic                rst_n,
  immediate_encoder_if.slave  bus
);

  typedef struct packed {
    logic [2:0]  err;
    logic [31:0] instr;
  } entry_t;

  entry_t      mem_q [2];
  entry_t      enc;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        live_q;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        push, pop;

  // True when imm[31:lsb] are all equal, i.e. the value survives truncation to lsb+1 signed bits.
  function automatic logic fits(input logic [31:0] imm, input int unsigned lsb);
    logic signed [31:0] sh;
    sh = $signed(imm) >>> lsb;
    return (sh == '0) || (sh == '1);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  function automatic entry_t encode(input logic [2:0] t, input logic [31:0] imm,
                                    input logic [31:0] base);
    entry_t e;
    e.err   = '0;
    e.instr = base;
    case (t)
      3'd0: begin
        e.instr  = {imm[11:0], base[19:0]};
        e.err[0] = !fits(imm, 11);
      end
      3'd1: begin
        e.instr  = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
        e.err[0] = !fits(imm, 11);
      end
      3'd2: begin
        e.instr  = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
        e.err[0] = !fits(imm, 12);
        e.err[1] = imm[0];
      end
      3'd3: begin
        e.instr  = {imm[31:12], base[11:0]};
        e.err[1] = (imm[11:0] != 12'd0);
      end
      3'd4: begin
        e.instr  = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
        e.err[0] = !fits(imm, 20);
        e.err[1] = imm[0];
      end
      default: e.err = 3'b100;
    endcase
    return e;
  endfunction

  assign enc  = encode(bus.imm_type, bus.imm_value, bus.base_instr);
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_comb begin
    wr_d      = wr_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    err_cnt_d = err_cnt_q;
    if (push) begin
      wr_d = ~wr_q;
      if (enc.err != 3'b000) err_cnt_d = sat_inc(err_cnt_q);
    end
    if (pop) rd_d = ~rd_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // live_q keeps in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      cnt_q     <= 2'd0;
      live_q    <= 1'b0;
      err_cnt_q <= 16'd0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      live_q    <= 1'b1;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= enc;
  end

  // Outputs are gated by valid so stale storage never shows, including during reset.
  assign bus.in_ready  = live_q && (cnt_q != 2'd2);
  assign bus.out_valid = (cnt_q != 2'd0);
  assign bus.out_instr = bus.out_valid ? mem_q[rd_q].instr : 32'd0;
  assign bus.out_err   = bus.out_valid ? mem_q[rd_q].err   : 3'd0;
  assign bus.err_count = err_cnt_q;

endmodule

// File: tb/tb_immediate_encoder.sv
// Directed vectors, back-pressure/reset sequences and random traffic against a queue-based model.
module tb_immediate_encoder;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  immediate_encoder_if bus();

  immediate_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  t;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] exp_instr;
    logic [2:0]  exp_err;
  } vec_t;

  logic [34:0] q[$];
  logic [31:0] popped[$];
  int          m_cnt = 0;
  bit          live = 0;
  bit          mready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: start from base, overwrite the immediate fields, judge range from the signed value.
  function automatic logic [34:0] model(input logic [2:0] t, input logic [31:0] imm,
                                        input logic [31:0] base);
    int          v;
    logic [31:0] r;
    logic [2:0]  e;
    v = $signed(imm);
    r = base;
    e = 3'b000;
    case (t)
      3'd0: begin
        r[31:20] = imm[11:0];
        e[0] = (v < -2048) || (v > 2047);
      end
      3'd1: begin
        r[31:25] = imm[11:5];
        r[11:7]  = imm[4:0];
        e[0] = (v < -2048) || (v > 2047);
      end
      3'd2: begin
        r[31] = imm[12]; r[7] = imm[11]; r[30:25] = imm[10:5]; r[11:8] = imm[4:1];
        e[0] = (v < -4096) || (v > 4095);
        e[1] = (v % 2) != 0;
      end
      3'd3: begin
        r[31:12] = imm[31:12];
        e[1] = (v % 4096) != 0;
      end
      3'd4: begin
        r[31] = imm[20]; r[30:21] = imm[10:1]; r[20] = imm[11]; r[19:12] = imm[19:12];
        e[0] = (v < -(1 << 20)) || (v > (1 << 20) - 1);
        e[1] = (v % 2) != 0;
      end
      default: e = 3'b100;
    endcase
    return {e, r};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_cnt = 0;
      live  = 0;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
      chk("rst_out_instr", bus.out_instr,      32'd0);
      chk("rst_out_err",   32'(bus.out_err),   32'd0);
      chk("rst_err_count", 32'(bus.err_count), 32'd0);
    end else begin
      mready = live && (q.size() < 2);
      chk("mon_in_ready",  32'(bus.in_ready),  32'(mready));
      chk("mon_out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      chk("mon_err_count", 32'(bus.err_count), 32'(m_cnt));
      if (q.size() != 0) begin
        chk("mon_out_instr", bus.out_instr,    q[0][31:0]);
        chk("mon_out_err",   32'(bus.out_err), 32'(q[0][34:32]));
        if (bus.out_ready) begin
          popped.push_back(bus.out_instr);
          void'(q.pop_front());
        end
      end
      if (bus.in_valid && mready) begin
        q.push_back(model(bus.imm_type, bus.imm_value, bus.base_instr));
        if (q[q.size()-1][34:32] != 3'b000 && m_cnt < 65535) m_cnt++;
      end
      live = 1;
    end
  end

  task automatic drive(input logic v, input logic [2:0] t, input logic [31:0] imm,
                       input logic [31:0] base);
    bus.in_valid   = v;
    bus.imm_type   = t;
    bus.imm_value  = imm;
    bus.base_instr = base;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    vec_t vecs[13];
    bit   acc;
    logic [31:0] imm;

    vecs[0]  = '{3'd0, 32'hFFFFF800, 32'h00000013, 32'h80000013, 3'b000};
    vecs[1]  = '{3'd2, 32'h00000FFE, 32'h00000063, 32'h7E000FE3, 3'b000};
    vecs[2]  = '{3'd2, 32'h00001000, 32'h00000063, 32'h80000063, 3'b001};
    vecs[3]  = '{3'd3, 32'h12345000, 32'h000000B7, 32'h123450B7, 3'b000};
    vecs[4]  = '{3'd4, 32'h00000001, 32'h0000006F, 32'h0000006F, 3'b010};
    vecs[5]  = '{3'd6, 32'h00000005, 32'hDEADBEEF, 32'hDEADBEEF, 3'b100};
    vecs[6]  = '{3'd1, 32'hFFFFFFFF, 32'h00000023, 32'hFE000FA3, 3'b000};
    vecs[7]  = '{3'd0, 32'h00000800, 32'h00000013, 32'h80000013, 3'b001};
    vecs[8]  = '{3'd3, 32'h00000001, 32'h00000037, 32'h00000037, 3'b010};
    vecs[9]  = '{3'd4, 32'h00100000, 32'h0000006F, 32'h8000006F, 3'b001};
    vecs[10] = '{3'd0, 32'h00000000, 32'hFFFFFFFF, 32'h000FFFFF, 3'b000};
    vecs[11] = '{3'd4, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFF000, 3'b000};
    vecs[12] = '{3'd2, 32'hFFFFF001, 32'h00000063, 32'h80000063, 3'b010};

    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    #2;
    chk("init_out_valid", 32'(bus.out_valid), 32'd0);
    chk("init_err_count", 32'(bus.err_count), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("ready_before_edge", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    chk("ready_after_edge", 32'(bus.in_ready), 32'd1);

    // Directed table, one request at a time with the consumer always ready.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, vecs[i].t, vecs[i].imm, vecs[i].base);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk($sformatf("vec%0d_latency", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("vec%0d_instr", i),   bus.out_instr,      vecs[i].exp_instr);
      chk($sformatf("vec%0d_err", i),     32'(bus.out_err),   32'(vecs[i].exp_err));
      @(posedge clk); #1;
    end
    chk("table_err_count", 32'(bus.err_count), 32'd7);

    // Back-pressure: two fill the FIFO, the third waits until a slot frees.
    popped.delete();
    bus.out_ready = 1'b0;
    drive(1'b1, 3'd0, 32'd1, 32'h13);
    @(posedge clk); #1;
    drive(1'b1, 3'd0, 32'd2, 32'h13);
    @(posedge clk); #1;
    drive(1'b1, 3'd0, 32'd3, 32'h13);
    chk("bp_full_ready", 32'(bus.in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_still_blocked", 32'(bus.in_ready), 32'd0);
    chk("bp_head_held", bus.out_instr, 32'h00100013);
    bus.out_ready = 1'b1;
    acc = 0;
    for (int c = 0; c < 10 && !acc; c++) begin
      if (bus.in_ready) acc = 1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("bp_third_accepted", 32'(acc), 32'd1);
    for (int c = 0; c < 10 && bus.out_valid; c++) begin
      @(posedge clk); #1;
    end
    chk("bp_pop_count", 32'(popped.size()), 32'd3);
    if (popped.size() == 3) begin
      chk("bp_order0", popped[0], 32'h00100013);
      chk("bp_order1", popped[1], 32'h00200013);
      chk("bp_order2", popped[2], 32'h00300013);
    end

    // Reset asserted mid-cycle with two errored entries buffered.
    bus.out_ready = 1'b0;
    drive(1'b1, 3'd4, 32'd1, 32'h6F);
    @(posedge clk); #1;
    drive(1'b1, 3'd4, 32'd3, 32'h6F);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("pre_rst_err_count", 32'(bus.err_count), 32'd9);
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_err_count", 32'(bus.err_count), 32'd0);
    chk("async_in_ready",  32'(bus.in_ready),  32'd0);
    chk("async_out_instr", bus.out_instr,      32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("no_stale_result", 32'(bus.out_valid), 32'd0);
    chk("post_rst_count",  32'(bus.err_count), 32'd0);

    // Random traffic, including one reset in the middle.
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 3))
        0:       imm = $urandom;
        1:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2:       imm = $urandom & 32'hFFFFF000;
        default: imm = 32'($urandom_range(0, 4194303)) - 32'd2097152;
      endcase
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), imm, $urandom);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      if (c == 1500) begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("final_drained", 32'(bus.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
